// File: rtl/signmag_addsub_pipe_pkg.sv
//==============================================================================
// Module   : signmag_pkg
// Purpose  : Shared op encodings and stage-1 payload type for signmag_addsub_pipe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package signmag_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Magnitude fields are sized for the widest supported W; users take the low W bits.
    localparam int MAG_W_MAX = 64;

    typedef struct packed {
        logic [MAG_W_MAX-1:0] big_mag;
        logic [MAG_W_MAX-1:0] small_mag;
        logic                 big_sign;
        logic                 eff_sub;
    } stage1_t;

endpackage

`default_nettype wire

// File: rtl/signmag_addsub_pipe_if.sv
//==============================================================================
// Module   : signmag_addsub_pipe_if
// Purpose  : Operand/result valid-ready bundle for the sign-magnitude adder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface signmag_addsub_pipe_if #(
    parameter int W = 25
);
    localparam int LZC_W = $clog2(W + 1);

    logic             in_valid;
    logic             in_ready;
    logic             a_sign;
    logic [W-1:0]     a_mag;
    logic             b_sign;
    logic [W-1:0]     b_mag;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic             res_sign;
    logic [W-1:0]     res_mag;
    logic             res_carry;
    logic             res_zero;
    logic [LZC_W-1:0] res_lzc;

    modport master (
        output in_valid, a_sign, a_mag, b_sign, b_mag, op, out_ready,
        input  in_ready, out_valid, res_sign, res_mag, res_carry, res_zero, res_lzc
    );

    modport slave (
        input  in_valid, a_sign, a_mag, b_sign, b_mag, op, out_ready,
        output in_ready, out_valid, res_sign, res_mag, res_carry, res_zero, res_lzc
    );

endinterface

`default_nettype wire

// File: rtl/signmag_addsub_pipe_lzc.sv
//==============================================================================
// Module   : lzc_count
// Purpose  : Priority leading-zero counter; returns N when the input is all zero.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lzc_count #(
    parameter int N = 26
) (
    input  wire [N-1:0]               value,
    output logic [$clog2(N+1)-1:0]    count
);
    localparam int CNT_W = $clog2(N + 1);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CNT_W'(N);
        for (int i = 0; i < N; i++) begin
            if (value[i]) begin
                count = CNT_W'(N - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/signmag_addsub_pipe.sv
//==============================================================================
// Module   : signmag_addsub_pipe
// Purpose  : Two-stage sign-magnitude add/sub with valid/ready flow control.
//            Define SMAS_LZC_EN to register a leading-zero count with the result.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module signmag_addsub_pipe
    import signmag_pkg::*;
#(
    parameter int W = 25
) (
    input wire                   clk,
    input wire                   rst_n,
    signmag_addsub_pipe_if.slave bus
);
    localparam int LZC_W = $clog2(W + 1);

    logic         w_stall;
    logic         w_b_eff_sign;
    logic         w_eff_sub;
    logic         w_swap;
    stage1_t      w_s1_next;

    logic         r_s1_valid;
    stage1_t      r_s1;

    logic [W-1:0] w_big;
    logic [W-1:0] w_small;
    logic [W:0]   w_sum;
    logic [W-1:0] w_diff;
    logic [W:0]   w_wide;
    logic         w_zero;
    logic         w_sign;

    logic         r_out_valid;
    logic         r_res_sign;
    logic [W-1:0] r_res_mag;
    logic         r_res_carry;
    logic         r_res_zero;

    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // Order operands so stage 2 only ever subtracts the smaller magnitude.
    assign w_b_eff_sign = bus.b_sign ^ bus.op;
    assign w_eff_sub    = bus.a_sign ^ w_b_eff_sign;
    assign w_swap       = bus.b_mag > bus.a_mag;

    always_comb begin
        w_s1_next                    = '0;
        w_s1_next.big_mag[W-1:0]     = w_swap ? bus.b_mag : bus.a_mag;
        w_s1_next.small_mag[W-1:0]   = w_swap ? bus.a_mag : bus.b_mag;
        w_s1_next.big_sign           = w_swap ? w_b_eff_sign : bus.a_sign;
        w_s1_next.eff_sub            = w_eff_sub;
    end

    generate
        if (W < MAG_W_MAX) begin : g_pad
            wire pad_unused = |{r_s1.big_mag[MAG_W_MAX-1:W], r_s1.small_mag[MAG_W_MAX-1:W]};
        end
    endgenerate

    assign w_big   = r_s1.big_mag[W-1:0];
    assign w_small = r_s1.small_mag[W-1:0];
    assign w_sum   = {1'b0, w_big} + {1'b0, w_small};
    assign w_diff  = w_big - w_small;
    assign w_wide  = r_s1.eff_sub ? {1'b0, w_diff} : w_sum;
    // A carried-out sum with zero low bits is not a zero result.
    assign w_zero  = (w_wide == '0);
    assign w_sign  = r_s1.big_sign & ~w_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_res_sign  <= 1'b0;
            r_res_mag   <= '0;
            r_res_carry <= 1'b0;
            r_res_zero  <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid  <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_s1_next;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_sign  <= w_sign;
                r_res_mag   <= w_wide[W-1:0];
                r_res_carry <= w_wide[W];
                r_res_zero  <= w_zero;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.res_sign  = r_res_sign;
    assign bus.res_mag   = r_res_mag;
    assign bus.res_carry = r_res_carry;
    assign bus.res_zero  = r_res_zero;

`ifdef SMAS_LZC_EN
    logic [LZC_W-1:0] w_lzc;
    logic [LZC_W-1:0] r_lzc;

    lzc_count #(
        .N (W + 1)
    ) u_lzc (
        .value (w_wide),
        .count (w_lzc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lzc <= '0;
        end else if (!w_stall && r_s1_valid) begin
            r_lzc <= w_lzc;
        end
    end

    assign bus.res_lzc = r_lzc;
`else
    assign bus.res_lzc = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_signmag_addsub_pipe.sv
//==============================================================================
// Module   : tb_signmag_addsub_pipe
// Purpose  : Directed self-checking bench for signmag_addsub_pipe (W=25).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_signmag_addsub_pipe;
    import signmag_pkg::*;

    localparam int W     = 25;
    localparam int LZC_W = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    signmag_addsub_pipe_if #(.W(W)) bus ();

    signmag_addsub_pipe #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.a_sign   = 1'b0;
        bus.a_mag    = '0;
        bus.b_sign   = 1'b0;
        bus.b_mag    = '0;
        bus.op       = OP_ADD;
    endtask

    task automatic run_one(input string tag,
                           input logic as, input logic [W-1:0] am,
                           input logic bs, input logic [W-1:0] bm, input logic o,
                           input logic es, input logic [W-1:0] em,
                           input logic ec, input logic ez, input int el);
        logic [LZC_W-1:0] lzc_exp;
`ifdef SMAS_LZC_EN
        lzc_exp = LZC_W'(el);
`else
        lzc_exp = '0;
`endif
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a_sign    = as;
        bus.a_mag     = am;
        bus.b_sign    = bs;
        bus.b_mag     = bm;
        bus.op        = o;
        @(negedge clk);
        drive_idle();
        check({tag, "/lat1"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "/valid"}, bus.out_valid, 1'b1);
        check({tag, "/sign"},  bus.res_sign,  es);
        check({tag, "/mag"},   bus.res_mag,   em);
        check({tag, "/carry"}, bus.res_carry, ec);
        check({tag, "/zero"},  bus.res_zero,  ez);
        check({tag, "/lzc"},   bus.res_lzc,   lzc_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        int sent;
        int got;

        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst/out_valid", bus.out_valid, 1'b0);
        check("rst/in_ready",  bus.in_ready,  1'b1);
        check("rst/mag",       bus.res_mag,   '0);
        check("rst/sign",      bus.res_sign,  1'b0);
        check("rst/lzc",       bus.res_lzc,   '0);
        rst_n = 1'b1;

        run_one("p5_sub_p3",  0, 25'd5, 0, 25'd3, OP_SUB, 0, 25'd2, 0, 0, 24);
        run_one("p3_sub_p5",  0, 25'd3, 0, 25'd5, OP_SUB, 1, 25'd2, 0, 0, 24);
        run_one("m3_add_p5",  1, 25'd3, 0, 25'd5, OP_ADD, 0, 25'd2, 0, 0, 24);
        run_one("max_add_1",  0, 25'h1FFFFFF, 0, 25'd1, OP_ADD, 0, 25'd0, 1, 0, 0);
        run_one("m7_sub_m7",  1, 25'd7, 1, 25'd7, OP_SUB, 0, 25'd0, 0, 1, 26);
        run_one("m4_add_m6",  1, 25'd4, 1, 25'd6, OP_ADD, 1, 25'd10, 0, 0, 22);
        run_one("p6_add_m6",  0, 25'd6, 1, 25'd6, OP_ADD, 0, 25'd0, 0, 1, 26);
        run_one("m0_add_m0",  1, 25'd0, 1, 25'd0, OP_ADD, 0, 25'd0, 0, 1, 26);
        run_one("max_sub_m1", 0, 25'h1FFFFFF, 0, 25'h1FFFFFE, OP_SUB, 0, 25'd1, 0, 0, 25);

        // Ten back-to-back beats with downstream back-pressure on cycles 4..6.
        sent = 0;
        got  = 0;
        held = '0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 4 && c <= 6);
            bus.in_valid  = (sent < 10);
            bus.a_sign    = 1'b0;
            bus.a_mag     = W'(sent * 3 + 10);
            bus.b_sign    = 1'b0;
            bus.b_mag     = W'(sent);
            bus.op        = OP_ADD;
            #1;
            if (c >= 3 && c <= 7)
                check($sformatf("burst/in_ready_c%0d", c), bus.in_ready, (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
            if (c == 4) held = bus.res_mag;
            if (c == 5 || c == 6) check($sformatf("burst/hold_c%0d", c), bus.res_mag, held);
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("burst/mag%0d", got), bus.res_mag, 64'(4 * got + 10));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check("burst/count", 64'(got), 64'd10);
        @(negedge clk);
        drive_idle();
        bus.out_ready = 1'b1;
        #1;
        check("burst/no_dup", bus.out_valid, 1'b0);

        // Reset with two beats in flight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_mag    = 25'd9;
        bus.b_mag    = 25'd1;
        @(negedge clk);
        bus.a_mag    = 25'd8;
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("rstmid/out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rstmid/idle%0d", k), bus.out_valid, 1'b0);
        end
        run_one("post_rst", 0, 25'd20, 0, 25'd4, OP_ADD, 0, 25'd24, 0, 0, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
